// File: rtl/up_axi_initiator_pkg.sv
// Shared definitions for the up_axi_initiator register-bus to AXI4-Lite bridge.
// Holds the FSM state encoding, the AXI response codes and the read-data
// pattern returned when a transaction is abandoned by the response timeout.
package up_axi_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADDEAD;

endpackage

// File: rtl/up_axi_initiator.sv
// Purpose : bridges a held-level word-addressed register bus onto an AXI4-Lite master, one transaction at a time.
// Latency : request seen cycle 0, AXI valid cycle 1, response cycle 2, up_wack/up_rack cycle 3 with an always-ready slave.
// Backpr. : valids are held until their ready; new requests wait (never dropped) until the FSM is back in IDLE.
//
// Ports   : up_clk/up_rst (async active-high); up_wreq/up_waddr/up_wdata -> up_wack/up_werr;
//           up_rreq/up_raddr -> up_rack/up_rerr/up_rdata; m_axi_* is the AXI4-Lite master (aw, w, b, ar, r).
// Option  : define UP_AXI_INITIATOR_TIMEOUT_EN to add a TIMEOUT_CYCLES response timeout that acks with err=1.
module up_axi_initiator
  import up_axi_initiator_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         up_clk,
  input  logic                         up_rst,
  input  logic                         up_wreq,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
  input  logic [31:0]                  up_wdata,
  output logic                         up_wack,
  output logic                         up_werr,
  input  logic                         up_rreq,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
  output logic [31:0]                  up_rdata,
  output logic                         up_rack,
  output logic                         up_rerr,
  output logic                         m_axi_awvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  input  logic                         m_axi_awready,
  output logic                         m_axi_wvalid,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_wready,
  input  logic                         m_axi_bvalid,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_bready,
  output logic                         m_axi_arvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  input  logic                         m_axi_arready,
  input  logic                         m_axi_rvalid,
  input  logic [31:0]                  m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  output logic                         m_axi_rready
);

  state_t                       state_q, state_d;
  logic [AXI_ADDRESS_WIDTH-3:0] addr_q;
  logic [31:0]                  wdata_q;
  logic                         awvalid_q, wvalid_q;
  logic                         ack_busy, resp_hs, is_wr_state;
  logic                         to_fire, to_done;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_awaddr  = {addr_q, 2'b00};
  assign m_axi_araddr  = {addr_q, 2'b00};
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;

  // The requester still holds its level during the ack cycle; starting a new
  // transaction then would repeat the one just completed.
  assign ack_busy    = up_wack | up_rack;
  assign resp_hs     = (state_q == ST_WRESP && m_axi_bvalid) || (state_q == ST_RDATA && m_axi_rvalid);
  assign is_wr_state = (state_q == ST_WADDR) || (state_q == ST_WRESP);

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    m_axi_arvalid = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ack_busy) begin
          if (up_wreq)      state_d = ST_WADDR;
          else if (up_rreq) state_d = ST_RADDR;
        end
      end
      ST_WADDR: begin
        // aw and w may complete in different cycles; leave once neither is outstanding.
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = ST_IDLE;
      end
      ST_RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      up_wack   <= 1'b0;
      up_werr   <= 1'b0;
      up_rack   <= 1'b0;
      up_rerr   <= 1'b0;
      up_rdata  <= '0;
    end else begin
      up_wack <= 1'b0;
      up_werr <= 1'b0;
      up_rack <= 1'b0;
      up_rerr <= 1'b0;
      if (state_q == ST_IDLE && state_d == ST_WADDR) begin
        addr_q    <= up_waddr;
        wdata_q   <= up_wdata;
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end
      if (state_q == ST_IDLE && state_d == ST_RADDR) addr_q <= up_raddr;
      if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
      if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
      // A response arriving after a timeout ack is consumed silently.
      if (state_q == ST_WRESP && m_axi_bvalid && !to_done) begin
        up_wack <= 1'b1;
        up_werr <= (m_axi_bresp != AXI_RESP_OKAY);
      end
      if (state_q == ST_RDATA && m_axi_rvalid && !to_done) begin
        up_rack  <= 1'b1;
        up_rerr  <= (m_axi_rresp != AXI_RESP_OKAY);
        up_rdata <= m_axi_rdata;
      end
      if (to_fire) begin
        if (is_wr_state) begin
          up_wack <= 1'b1;
          up_werr <= 1'b1;
        end else begin
          up_rack  <= 1'b1;
          up_rerr  <= 1'b1;
          up_rdata <= TIMEOUT_RDATA;
        end
      end
    end
  end

`ifdef UP_AXI_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;
  logic        to_done_q;

  // Fires on the edge where the counter steps onto TO_LAST, so the error ack
  // is visible in the same cycle the counter shows TO_LAST. A real response
  // in that same cycle takes priority.
  assign to_fire = (state_q != ST_IDLE) && !to_done_q && !resp_hs && (16'(to_cnt_q + 16'd1) == TO_LAST);
  assign to_done = to_done_q;

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      to_cnt_q  <= '0;
      to_done_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      to_cnt_q  <= '0;
      to_done_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_q + 16'd1;
      if (to_fire) to_done_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign to_fire            = 1'b0;
  assign to_done            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_up_axi_initiator.sv
`timescale 1ns/1ps
module tb_up_axi_initiator;

  localparam int AW = 16;
  localparam int TO = 16;

  logic          up_clk = 1'b0;
  logic          up_rst = 1'b1;
  logic          up_wreq = 1'b0, up_rreq = 1'b0;
  logic [AW-3:0] up_waddr = '0, up_raddr = '0;
  logic [31:0]   up_wdata = '0;
  logic          up_wack, up_werr, up_rack, up_rerr;
  logic [31:0]   up_rdata;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic [31:0]   m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [1:0]    m_axi_bresp, m_axi_rresp;

  up_axi_initiator #(.AXI_ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack), .up_werr(up_werr),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack), .up_rerr(up_rerr),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready)
  );

  always #5 up_clk = ~up_clk;

  int cyc = 0;
  always @(posedge up_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_w;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Slave configuration: ready from an absolute cycle on, response codes/data, read stall.
  int          aw_from = 0, w_from = 0, ar_from = 0;
  bit          r_hold = 1'b0;
  logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
  logic [31:0] rdata_v = 32'h0;

  initial begin : slave
    bit aw_got, w_got, ar_got;
    aw_got = 0; w_got = 0; ar_got = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge up_clk);
      if (up_rst) begin
        aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_got = 1;
        if (m_axi_wvalid && m_axi_wready) w_got = 1;
        if (m_axi_bvalid && m_axi_bready) begin aw_got = 0; w_got = 0; end
        if (m_axi_arvalid && m_axi_arready) ar_got = 1;
        if (m_axi_rvalid && m_axi_rready) ar_got = 0;
      end
      @(posedge up_clk); #1;
      m_axi_awready = (cyc >= aw_from);
      m_axi_wready  = (cyc >= w_from);
      m_axi_arready = (cyc >= ar_from);
      m_axi_bvalid  = aw_got && w_got && !up_rst;
      m_axi_rvalid  = ar_got && !r_hold && !up_rst;
      m_axi_bresp   = bresp_v;
      m_axi_rresp   = rresp_v;
      m_axi_rdata   = rdata_v;
    end
  end

  // Monitor: scoreboard pop on every ack, plus valid-hold protocol checks.
  initial begin : monitor
    exp_t e;
    bit aw_p, w_p, ar_p;
    aw_p = 0; w_p = 0; ar_p = 0;
    forever begin
      @(negedge up_clk);
      if (up_rst) begin
        aw_p = 0; w_p = 0; ar_p = 0;
      end else begin
        if (aw_p) chk("awvalid_hold", m_axi_awvalid, 1);
        if (w_p)  chk("wvalid_hold", m_axi_wvalid, 1);
        if (ar_p) chk("arvalid_hold", m_axi_arvalid, 1);
        aw_p = m_axi_awvalid && !m_axi_awready;
        w_p  = m_axi_wvalid && !m_axi_wready;
        ar_p = m_axi_arvalid && !m_axi_arready;
        if (up_wack || up_rack) begin
          if (exp_q.size() == 0) begin
            chk("spurious_ack", {30'd0, up_wack, up_rack}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("ack_wack", up_wack, e.is_w);
            chk("ack_rack", up_rack, !e.is_w);
            chk("ack_cycle", cyc, e.cyc);
            if (e.is_w) chk("werr", up_werr, e.err);
            else begin
              chk("rerr", up_rerr, e.err);
              chk("rdata", up_rdata, e.rdata);
            end
          end
        end
      end
    end
  end

  task automatic begin_txn(output int t);
    @(posedge up_clk); #1;
    t = cyc + 1;
  endtask

  task automatic go();
    @(posedge up_clk); #1;
  endtask

  task automatic at_cyc(input int c);
    do @(negedge up_clk); while (cyc < c);
  endtask

  task automatic req_write(input logic [AW-3:0] a, input logic [31:0] d);
    int n = 0;
    up_waddr = a; up_wdata = d; up_wreq = 1'b1;
    do begin @(negedge up_clk); n++; end while (!up_wack && n < 300);
    chk("wack_seen", up_wack, 1);
    @(posedge up_clk); #1;
    up_wreq = 1'b0;
  endtask

  task automatic req_read(input logic [AW-3:0] a);
    int n = 0;
    up_raddr = a; up_rreq = 1'b1;
    do begin @(negedge up_clk); n++; end while (!up_rack && n < 300);
    chk("rack_seen", up_rack, 1);
    @(posedge up_clk); #1;
    up_rreq = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge up_clk); n++; end
    chk("queue_drain", exp_q.size(), 0);
    repeat (3) @(negedge up_clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0;
    // Reset state
    repeat (2) @(negedge up_clk);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_acks", {up_wack, up_werr, up_rack, up_rerr}, 0);
    chk("rst_rdata", up_rdata, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    go(); up_rst = 1'b0;
    repeat (2) @(negedge up_clk);

    // Write with always-ready slave
    begin_txn(t0);
    exp_q.push_back('{1'b1, 1'b0, 32'h0, t0 + 3});
    go();
    fork
      req_write(14'h010, 32'h12345678);
      begin
        at_cyc(t0 + 1);
        chk("w_awvalid_c1", m_axi_awvalid, 1);
        chk("w_awaddr_c1", m_axi_awaddr, 16'h0040);
        chk("w_wvalid_c1", m_axi_wvalid, 1);
        chk("w_wdata_c1", m_axi_wdata, 32'h12345678);
        chk("w_wstrb_c1", m_axi_wstrb, 4'hF);
        chk("w_awprot_c1", m_axi_awprot, 3'b000);
        at_cyc(t0 + 2);
        chk("w_bready_c2", m_axi_bready, 1);
      end
    join
    drain();

    // Read, slave returns 0xCAFEF00D OKAY
    begin_txn(t0);
    rdata_v = 32'hCAFEF00D;
    exp_q.push_back('{1'b0, 1'b0, 32'hCAFEF00D, t0 + 3});
    go();
    fork
      req_read(14'h003);
      begin
        at_cyc(t0 + 1);
        chk("r_arvalid_c1", m_axi_arvalid, 1);
        chk("r_araddr_c1", m_axi_araddr, 16'h000C);
        chk("r_arprot_c1", m_axi_arprot, 3'b000);
        at_cyc(t0 + 2);
        chk("r_rready_c2", m_axi_rready, 1);
      end
    join
    drain();

    // Split handshake: awready from cycle 1, wready from cycle 4
    begin_txn(t0);
    aw_from = t0 + 1; w_from = t0 + 4;
    exp_q.push_back('{1'b1, 1'b0, 32'h0, t0 + 6});
    go();
    fork
      req_write(14'h100, 32'h0F0F0F0F);
      begin
        at_cyc(t0 + 2);
        chk("s_awvalid_c2", m_axi_awvalid, 0);
        chk("s_wvalid_c2", m_axi_wvalid, 1);
        at_cyc(t0 + 4);
        chk("s_wvalid_c4", m_axi_wvalid, 1);
        chk("s_bready_c4", m_axi_bready, 0);
        at_cyc(t0 + 5);
        chk("s_wvalid_c5", m_axi_wvalid, 0);
        chk("s_bready_c5", m_axi_bready, 1);
      end
    join
    drain();
    aw_from = 0; w_from = 0;
    chk("rdata_hold", up_rdata, 32'hCAFEF00D);

    // Simultaneous write and read: write first, read after the write ack
    begin_txn(t0);
    rdata_v = 32'h0BADBEEF;
    exp_q.push_back('{1'b1, 1'b0, 32'h0, t0 + 3});
    exp_q.push_back('{1'b0, 1'b0, 32'h0BADBEEF, t0 + 7});
    go();
    fork
      req_write(14'h020, 32'hA5A50001);
      req_read(14'h004);
      begin
        at_cyc(t0 + 1);
        chk("b_awvalid_c1", m_axi_awvalid, 1);
        chk("b_arvalid_c1", m_axi_arvalid, 0);
        at_cyc(t0 + 5);
        chk("b_araddr_c5", m_axi_araddr, 16'h0010);
      end
    join
    drain();

    // Error responses
    begin_txn(t0);
    bresp_v = 2'b10;
    exp_q.push_back('{1'b1, 1'b1, 32'h0, t0 + 3});
    go();
    req_write(14'h3FFF, 32'h00000001);
    drain();
    bresp_v = 2'b00;
    begin_txn(t0);
    rresp_v = 2'b11; rdata_v = 32'h11112222;
    exp_q.push_back('{1'b0, 1'b1, 32'h11112222, t0 + 3});
    go();
    req_read(14'h3FFF);
    drain();
    rresp_v = 2'b00;

    // Stalled read: timeout ack (feature on) or indefinite wait (feature off)
    begin_txn(t0);
    r_hold = 1'b1; rdata_v = 32'h5555AAAA;
`ifdef UP_AXI_INITIATOR_TIMEOUT_EN
    exp_q.push_back('{1'b0, 1'b1, 32'hDEADDEAD, t0 + TO});
    go();
    fork
      req_read(14'h005);
      begin
        at_cyc(t0 + 24);
        r_hold = 1'b0;
        at_cyc(t0 + 30);
        chk("to_rdata_after_late", up_rdata, 32'hDEADDEAD);
        chk("to_back_idle", m_axi_rready, 0);
      end
    join
`else
    exp_q.push_back('{1'b0, 1'b0, 32'h5555AAAA, t0 + 31});
    go();
    fork
      req_read(14'h005);
      begin
        at_cyc(t0 + 20);
        chk("stall_rready_c20", m_axi_rready, 1);
        at_cyc(t0 + 29);
        r_hold = 1'b0;
      end
    join
`endif
    r_hold = 1'b0;
    drain();

    // Reset in the middle of a write: abandoned, never acked
    begin_txn(t0);
    aw_from = 32'h7FFFFFFF; w_from = 32'h7FFFFFFF;
    go();
    up_waddr = 14'h0AA; up_wdata = 32'hFEEDFACE; up_wreq = 1'b1;
    at_cyc(t0 + 3);
    chk("mr_awvalid_pend", m_axi_awvalid, 1);
    #2;
    up_rst = 1'b1; up_wreq = 1'b0;
    #1;
    chk("mr_awvalid_rst", m_axi_awvalid, 0);
    chk("mr_wvalid_rst", m_axi_wvalid, 0);
    chk("mr_awaddr_rst", m_axi_awaddr, 0);
    repeat (2) @(posedge up_clk);
    #1;
    up_rst = 1'b0; aw_from = 0; w_from = 0;
    repeat (10) @(negedge up_clk);
    chk("mr_queue_empty", exp_q.size(), 0);

    // Recovery after reset
    begin_txn(t0);
    exp_q.push_back('{1'b1, 1'b0, 32'h0, t0 + 3});
    go();
    req_write(14'h001, 32'h00C0FFEE);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
